// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame scheduler.
// Frame layout: SYNC, ID, DATA_HI, DATA_LO, CHK.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_e;

  localparam int FRAME_LEN = 5;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  function automatic logic [7:0] frame_chk(
    input logic [7:0]  id,
    input logic [15:0] d
  );
    return id + d[15:8] + d[7:0];
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter with a last-grant pointer.
// The search starts one past the last winner and wraps at N-1.
module rr_arbiter
  import uart_frame_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 adv_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  logic [W-1:0] last_q;
  logic [W-1:0] last_d;
  logic [W-1:0] cand;
  logic         found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = last_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int j = 0; j < N; j++) begin
      gnt_o[j] = found && (idx_o == W'(j));
    end
  end

  assign last_d = adv_i ? idx_o : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters.
// Each grant becomes a 5-byte frame issued via start/busy.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [16*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_busy_i,
  output logic                    sched_busy_o,
  output logic                    frame_done_o
);

  localparam int IW = $clog2(NUM_REQ);

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [IW-1:0] id_q;
  logic [15:0]   data_q;
  logic          start_q;
  logic [7:0]    txd_q;
  logic          done_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               can_grant;
  logic               adv;
  logic [7:0]         id8;
  logic [2:0]         idx_d;

  assign can_grant   = (state_q == IDLE) && !tx_busy_i;
  assign req_ready_o = can_grant ? gnt : '0;
  assign adv         = |req_ready_o;
  assign id8         = 8'(id_q);
  assign idx_d       = idx_q + 3'd1;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid_i),
    .adv_i (adv),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  function automatic logic [7:0] frame_byte(
    input logic [2:0]  i,
    input logic [7:0]  id,
    input logic [15:0] d
  );
    logic [7:0] b;
    unique case (i)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = id;
      3'd2:    b = d[15:8];
      3'd3:    b = d[7:0];
      default: b = frame_chk(id, d);
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      txd_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (adv) begin
            id_q    <= gidx;
            data_q  <= req_data_i[16*gidx +: 16];
            idx_q   <= '0;
            start_q <= 1'b1;
            txd_q   <= SYNC_BYTE;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy_i) begin
            state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_busy_i) begin
            if (idx_q < 3'(FRAME_LEN - 1)) begin
              idx_q   <= idx_d;
              start_q <= 1'b1;
              txd_q   <= frame_byte(idx_d, id8, data_q);
              state_q <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start_o   = start_q;
  assign tx_data_o    = txd_q;
  assign frame_done_o = done_q;
  assign sched_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler.
// A behavioural transmitter holds busy for BUSY cycles per byte.
module tb_uart_frame_scheduler;

  localparam int N    = 4;
  localparam int BUSY = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            sched_busy;
  logic            frame_done;

  int errors = 0;
  int checks = 0;
  int nstart = 0;
  int ndone = 0;
  int bcnt = 0;
  int mstarts = 0;
  int stall_at = -1;
  logic [7:0] exp_q[$];

  uart_frame_scheduler #(
    .NUM_REQ(N),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .tx_busy_i    (tx_busy),
    .sched_busy_o (sched_busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  assign tx_busy = (bcnt != 0);

  always @(posedge clk) begin
    if (bcnt != 0) bcnt <= bcnt - 1;
    if (tx_start) begin
      mstarts <= mstarts + 1;
      bcnt <= (mstarts + 1 == stall_at) ? BUSY + 100 : BUSY;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      nstart++;
      if (exp_q.size() == 0) check("unexp_start", 1, 0);
      else check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
    if (frame_done) ndone++;
  end

  task automatic push5(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input logic [7:0] e);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int id, input logic [15:0] d);
    int s;
    s = (id + d[15:8] + d[7:0]) % 256;
    push5(8'hA5, 8'(id), d[15:8], d[7:0], 8'(s));
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] d);
    req_valid[i] = v;
    req_data[16*i +: 16] = d;
  endtask

  task automatic wait_grant(input int idx);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", {28'h0, req_ready}, 32'(1 << idx));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 1000);
    if (!frame_done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (nstart < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (nstart < target) check("start_timeout", nstart, target);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_ready"}, {28'h0, req_ready}, 0);
    check({tag, "_start"}, {31'h0, tx_start}, 0);
    check({tag, "_data"}, {24'h0, tx_data}, 0);
    check({tag, "_sbusy"}, {31'h0, sched_busy}, 0);
    check({tag, "_done"}, {31'h0, frame_done}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bs, bd, n, bad_s, bad_d;
    @(negedge clk);
    #1;
    check_idle_outs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // round robin with all requesters valid
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'(i));
    for (int k = 0; k < 5; k++) push_frame(k % N, 16'(k % N));
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % N);
      @(negedge clk);
      if (k == 4) req_valid = '0;
    end
    wait_done();

    // single frame, latency, pulse counts
    @(negedge clk);
    #1;
    bs = nstart;
    bd = ndone;
    set_req(1, 1'b1, 16'h1234);
    push5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h47);
    wait_grant(1);
    @(negedge clk);
    check("lat_start", {31'h0, tx_start}, 1);
    check("lat_data", {24'h0, tx_data}, 32'hA5);
    check("sbusy_hi", {31'h0, sched_busy}, 1);
    req_valid[1] = 1'b0;
    wait_done();
    @(negedge clk);
    #1;
    check("n_starts", nstart - bs, 5);
    check("n_done", ndone - bd, 1);
    check("sbusy_lo", {31'h0, sched_busy}, 0);

    // checksum wrap
    set_req(2, 1'b1, 16'hFFFF);
    push5(8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00);
    wait_grant(2);
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_done();

    // handshake stall on the third byte
    @(negedge clk);
    #1;
    bs = nstart;
    stall_at = mstarts + 3;
    set_req(0, 1'b1, 16'h1234);
    push_frame(0, 16'h1234);
    wait_grant(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_starts(bs + 3);
    n = 0;
    bad_s = 0;
    bad_d = 0;
    do begin
      @(negedge clk);
      #1;
      if (tx_busy) begin
        n++;
        if (tx_start) bad_s++;
        if (tx_data != 8'h12) bad_d++;
      end
    end while (tx_busy && n < 500);
    check("stall_len", {31'h0, n >= 100}, 1);
    check("stall_start", bad_s, 0);
    check("stall_data", bad_d, 0);
    wait_done();

    // back-to-back grant on the frame_done cycle
    set_req(0, 1'b1, 16'h5A5A);
    push_frame(0, 16'h5A5A);
    push_frame(3, 16'h0F0F);
    push_frame(0, 16'h8001);
    wait_grant(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(3, 1'b1, 16'h0F0F);
    wait_done();
    set_req(0, 1'b1, 16'h8001);
    #1;
    check("b2b_grant", {28'h0, req_ready}, 32'h8);
    @(negedge clk);
    check("b2b_start", {31'h0, tx_start}, 1);
    req_valid[3] = 1'b0;
    wait_grant(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_done();

    // reset in the middle of byte 2
    @(negedge clk);
    #1;
    bs = nstart;
    set_req(1, 1'b1, 16'hABCD);
    push_frame(1, 16'hABCD);
    wait_grant(1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_starts(bs + 3);
    @(negedge clk);
    set_req(1, 1'b1, 16'h0102);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_idle_outs("mrst");
    check("mrst_busy", {31'h0, tx_busy}, 1);
    push5(8'hA5, 8'h01, 8'h01, 8'h02, 8'h04);
    repeat (3) @(negedge clk);
    #1;
    check_idle_outs("mrst2");
    rst_n = 1'b1;
    check("rel_busy", {31'h0, tx_busy}, 1);
    n = 0;
    bad_s = 0;
    while (tx_busy && n < 200) begin
      if (req_ready != '0 || tx_start) bad_s++;
      @(negedge clk);
      #1;
      n++;
    end
    check("rel_hold", bad_s, 0);
    wait_grant(1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
